isqrt_seq: RTL
==============

Name: isqrt_seq

Overview:
Iterative unsigned integer square root. It is the inverse of the team's combinational squarer: given radicand X, it returns root R = floor(sqrt(X)) and remainder X - R*R. It uses a restoring digit-by-digit algorithm that produces one root bit per clock. The block sits behind a valid/ready input port and a valid/ready output port, so it can drop into the lab datapath between an operand register and a result consumer.

Parameters:
WIDTH, 8, radicand width in bits; must be even and >= 2 (elaboration error otherwise)
N, WIDTH/2 (derived localparam, not overridable), root width and iteration count

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  radicand offered
in_ready  output  1  block can accept a radicand (high only in IDLE)
in_x  input  WIDTH  unsigned radicand
out_valid  output  1  result held valid
out_ready  input  1  consumer accepts result
out_root  output  N  floor(sqrt(in_x))
out_rem  output  N+1  in_x - out_root^2 (max 2*root, so N+1 bits)
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ports clk, rst_n). While rst_n is low: state=IDLE, in_ready=1, out_valid=0, busy=0, out_root=0, out_rem=0, and internal x_sh, cnt, root and rem all 0.
- States:
  - IDLE: in_ready=1. If in_valid is high on a clock edge, latch in_x into shift register x_sh, clear root and rem, set cnt=N-1, and go to CALC.
  - CALC: one iteration per edge. Compute trial = {rem, x_sh[WIDTH-1:WIDTH-2]} - {root, 2'b01}, evaluated N+3 bits wide.
    - If trial >= 0: rem=trial and root={root,1}.
    - Otherwise: rem={rem, top two bits} and root={root,0}.
    - Then x_sh <<= 2. If cnt==0, go to DONE; otherwise cnt-1.
  - DONE: out_valid=1 with out_root and out_rem stable. On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly N edges after the accepting edge (WIDTH=8: 4 edges). Throughput is at most one result per N+2 cycles.
- in_valid while not in IDLE is ignored (in_ready=0). in_x is sampled only on the accepting edge, so later changes have no effect.
- Outputs are registered. out_root and out_rem update only on the edge entering DONE and otherwise hold their last value, including after returning to IDLE.
- out_ready asserted outside DONE has no effect.
- Back-pressure: DONE is held indefinitely while out_ready=0.
- If rst_n asserts mid-CALC or mid-DONE, the operation is abandoned immediately and outputs go to reset values. There is no partial result.
- Boundaries: x=0 gives root 0, rem 0. x=2^WIDTH-1 gives root 2^N-1, rem 2^(N+1)-2. Perfect squares give rem 0.
- Invariants: root^2 + rem == x and rem <= 2*root.

Optional Feature:
SQRT_EXACT_FLAG_EN
- Defined: adds output port out_exact (1 bit). It is registered with the result, and is 1 when the final rem==0 (X is a perfect square), else 0. Reset value 0; it holds like out_root.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package isqrt_pkg: state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2, plus a width-check helper function.
- Sub-module isqrt_step: combinational single iteration. Inputs are rem, root and the top two radicand bits; outputs are next rem, next root and the trial-sign bit. The top level instantiates it once and holds the FSM, counter and registers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles then release. Expect in_ready=1, out_valid=0, busy=0, out_root=0, out_rem=0.
- WIDTH=8, x=144: expect out_valid exactly 4 edges after acceptance, out_root=12, out_rem=0, out_exact=1 when enabled. x=255: out_root=15, out_rem=30. x=0: out_root=0, out_rem=0.
- Back-pressure: after x=200, hold out_ready=0 for 5 cycles. Expect out_valid=1 and out_root=14, out_rem=4 held stable. Then out_ready=1: IDLE on the next edge, in_ready=1.
- Ignored input: pulse in_valid with x=99 during CALC of x=50. Expect result root 7, rem 1, with x=99 never accepted.
- Reset mid-op: assert rst_n low 2 edges into CALC. Expect immediate return to IDLE, outputs 0, and a subsequent x=81 giving root 9, rem 0.
- Exhaustive sweep: x=0..255 back-to-back with out_ready=1. Check root^2+rem==x and rem<=2*root for every x.

Source files
------------

// File: rtl/isqrt_pkg.sv
// rtl/isqrt_pkg.sv - shared state encoding and parameter check for the iterative square root
package isqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic bit widthOk(int width);
    return (width >= 2) && (width % 2 == 0);
  endfunction

endpackage

// File: rtl/isqrt_if.sv
// rtl/isqrt_if.sv - radicand/result handshake bundle for isqrt_seq
// out_exact is present only when SQRT_EXACT_FLAG_EN is defined
interface isqrt_if #(
  parameter int WIDTH = 8
);
  localparam int N = WIDTH / 2;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_root;
  logic [N:0]       out_rem;
  logic             busy;
`ifdef SQRT_EXACT_FLAG_EN
  logic             out_exact;
`endif

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_root, out_rem, busy
`ifdef SQRT_EXACT_FLAG_EN
    , input out_exact
`endif
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_root, out_rem, busy
`ifdef SQRT_EXACT_FLAG_EN
    , output out_exact
`endif
  );

endinterface

// File: rtl/isqrt_step.sv
// rtl/isqrt_step.sv - one restoring square-root iteration: trial subtract, keep or restore
module isqrt_step #(
  parameter int N = 4
) (
  input  logic [N:0]   rem,
  input  logic [N-1:0] root,
  input  logic [1:0]   xTop,
  output logic [N:0]   remNext,
  output logic [N-1:0] rootNext,
  output logic         trialNeg
);

  logic [N+2:0] shifted;
  logic [N+2:0] trial;
  logic [N:0]   rootExt;

  // The partial remainder never exceeds twice the partial root, so bit N+2 is a true sign bit.
  always_comb begin
    shifted  = {rem, xTop};
    trial    = shifted - {1'b0, root, 2'b01};
    trialNeg = trial[N+2];
    remNext  = trialNeg ? shifted[N:0] : trial[N:0];
    rootExt  = {root, ~trialNeg};
    rootNext = rootExt[N-1:0];
  end

endmodule

// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - sequential restoring integer square root, one root bit per clock
// Optional registered out_exact (perfect-square) flag: define SQRT_EXACT_FLAG_EN
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  isqrt_if.slave bus
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!widthOk(WIDTH)) begin : gWidthCheck
    $error("isqrt_seq: WIDTH must be even and >= 2");
  end

  state_t           st;
  state_t           stNext;
  logic [WIDTH-1:0] xSh;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     root;
  logic [N:0]       rem;
  logic [N-1:0]     outRoot;
  logic [N:0]       outRem;
  logic [N:0]       remNext;
  logic [N-1:0]     rootNext;
  logic             trialNeg;

  isqrt_step #(.N(N)) uStep (
    .rem      (rem),
    .root     (root),
    .xTop     (xSh[WIDTH-1:WIDTH-2]),
    .remNext  (remNext),
    .rootNext (rootNext),
    .trialNeg (trialNeg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= stNext;
  end

  always_comb begin
    stNext = st;
    case (st)
      ST_IDLE: if (bus.in_valid)   stNext = ST_CALC;
      ST_CALC: if (cnt == '0)      stNext = ST_DONE;
      ST_DONE: if (bus.out_ready)  stNext = ST_IDLE;
      default:                     stNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xSh     <= '0;
      cnt     <= '0;
      root    <= '0;
      rem     <= '0;
      outRoot <= '0;
      outRem  <= '0;
    end else begin
      case (st)
        ST_IDLE: if (bus.in_valid) begin
          xSh  <= bus.in_x;
          root <= '0;
          rem  <= '0;
          cnt  <= CW'(N - 1);
        end
        ST_CALC: begin
          xSh  <= xSh << 2;
          root <= rootNext;
          rem  <= remNext;
          cnt  <= cnt - 1'b1;
          // Result registers move only on the edge into DONE and hold afterwards.
          if (cnt == '0) begin
            outRoot <= rootNext;
            outRem  <= remNext;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (st == ST_CALC) begin
      assert (rootNext[0] == !trialNeg);
    end
  end

`ifdef SQRT_EXACT_FLAG_EN
  logic outExact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         outExact <= 1'b0;
    else if (st == ST_CALC && cnt == '0) outExact <= (remNext == '0);
  end

  assign bus.out_exact = outExact;
`endif

  assign bus.in_ready  = (st == ST_IDLE);
  assign bus.out_valid = (st == ST_DONE);
  assign bus.busy      = (st != ST_IDLE);
  assign bus.out_root  = outRoot;
  assign bus.out_rem   = outRem;

endmodule
